// File: rtl/text_pkg.sv
// Shared constants and types for the text console: screen geometry, ASCII codes and FSM states.
// TEXT_CONSOLE_TAB_EN (optional define) enables TAB handling in text_console_ctrl.
package text_pkg;

  localparam int COLS   = 100;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;
  localparam int X_W    = 7;
  localparam int Y_W    = 5;

  localparam logic [X_W-1:0]    X_LAST      = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    Y_LAST      = Y_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(CELLS - 1);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;

  typedef enum logic [1:0] {IDLE, PROC, CLR_LINE, CLR_SCREEN} state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= SPACE) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/cursor_blink_gen.sv
// Cursor blink phase generator: toggles every BLINK_CYCLES clocks, restart forces the visible phase.
module cursor_blink_gen #(
  parameter int BLINK_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink
);

  localparam int CNT_W = $clog2(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      blink <= 1'b1;
    end else if (restart) begin
      cnt_q <= '0;
      blink <= 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      blink <= ~blink;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream text console: interprets ASCII/control codes, writes text VRAM, owns cursor and blink.
// Define TEXT_CONSOLE_TAB_EN to make 0x09 advance to the next 8-column tab stop.
module text_console_ctrl
  import text_pkg::*;
#(
  parameter int BLINK_CYCLES = 20_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [7:0]        vram_wdata,
  output logic [X_W-1:0]    cursor_x,
  output logic [Y_W-1:0]    cursor_y,
  output logic              cursor_blink,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [X_W-1:0]    x_d;
  logic [Y_W-1:0]    y_d;
  logic              adv_row;
  logic              we_d, ready_d, busy_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;
  logic              accept;
`ifdef TEXT_CONSOLE_TAB_EN
  logic [X_W:0]      tab_x;
`endif

  assign accept = char_valid && char_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLR_SCREEN;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    x_d        = cursor_x;
    y_d        = cursor_y;
    row_base_d = row_base_q;
    clr_cnt_d  = clr_cnt_q;
    adv_row    = 1'b0;
`ifdef TEXT_CONSOLE_TAB_EN
    tab_x      = '0;
`endif
    unique case (state_q)
      IDLE: if (accept) state_d = PROC;
      PROC: begin
        state_d = IDLE;
        if (is_printable(data_q)) begin
          if (cursor_x == X_LAST) begin
            x_d     = '0;
            adv_row = 1'b1;
          end else begin
            x_d = cursor_x + 7'd1;
          end
        end else begin
          case (data_q)
            CR: x_d = '0;
            LF: begin
              x_d     = '0;
              adv_row = 1'b1;
            end
            BS: if (cursor_x != '0) x_d = cursor_x - 7'd1;
            FF: begin
              x_d        = '0;
              y_d        = '0;
              row_base_d = '0;
              clr_cnt_d  = '0;
              state_d    = CLR_SCREEN;
            end
            TAB: begin
`ifdef TEXT_CONSOLE_TAB_EN
              tab_x = {1'b0, cursor_x & ~7'd7} + 8'd8;
              if (tab_x >= (X_W+1)'(COLS)) begin
                x_d     = '0;
                adv_row = 1'b1;
              end else begin
                x_d = tab_x[X_W-1:0];
              end
`endif
            end
            default: ;
          endcase
        end
        // Bottom row wraps to the top (no scroll) and the new row is blanked.
        if (adv_row) begin
          if (cursor_y == Y_LAST) begin
            y_d        = '0;
            row_base_d = '0;
            clr_cnt_d  = '0;
            state_d    = CLR_LINE;
          end else begin
            y_d        = cursor_y + 5'd1;
            row_base_d = row_base_q + ROW_STEP;
          end
        end
      end
      CLR_LINE: begin
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == LINE_LAST) state_d = IDLE;
      end
      CLR_SCREEN: begin
        clr_cnt_d = clr_cnt_q + 12'd1;
        if (clr_cnt_q == SCREEN_LAST) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    waddr_d = vram_waddr;
    wdata_d = vram_wdata;
    unique case (state_q)
      PROC: begin
        if (is_printable(data_q)) begin
          we_d    = 1'b1;
          waddr_d = row_base_q + ADDR_W'(cursor_x);
          wdata_d = data_q;
        end else if (data_q == BS && cursor_x != '0) begin
          we_d    = 1'b1;
          waddr_d = row_base_q + ADDR_W'(cursor_x - 7'd1);
          wdata_d = SPACE;
        end
      end
      CLR_LINE: begin
        we_d    = 1'b1;
        waddr_d = row_base_q + clr_cnt_q;
        wdata_d = SPACE;
      end
      CLR_SCREEN: begin
        we_d    = 1'b1;
        waddr_d = clr_cnt_q;
        wdata_d = SPACE;
      end
      default: ;
    endcase
    // busy lines up with the visible clear writes; ready waits one cycle past the last one.
    busy_d  = (state_q == CLR_LINE) || (state_q == CLR_SCREEN);
    ready_d = (state_d == IDLE) && !busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      row_base_q <= '0;
      clr_cnt_q  <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      if (accept) data_q <= char_data;
      row_base_q <= row_base_d;
      clr_cnt_q  <= clr_cnt_d;
      cursor_x   <= x_d;
      cursor_y   <= y_d;
      vram_we    <= we_d;
      vram_waddr <= waddr_d;
      vram_wdata <= wdata_d;
      char_ready <= ready_d;
      busy       <= busy_d;
    end
  end

  cursor_blink_gen #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .blink   (cursor_blink)
  );

endmodule
